// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline sequencing controller for the 5-stage core.
//
// Merges ID/EX stall requests into the per-stage stall vector. Runs the
// exception/ERET redirect: one registered flush cycle carrying new_pc, then
// a guard window in which further exceptions are ignored. Also watches the
// length of PC stalls and raises a sticky timeout flag.
//
// Ports
//   clk              core clock, all state on posedge
//   rst              synchronous reset, active-low
//   stallreq_from_id stall request from ID
//   stallreq_from_ex stall request from EX (multi-cycle op)
//   excepttype_i     exception code from MEM, 0 = none
//   cp0_epc_i        current CP0 EPC (ERET target)
//   stall[5:0]       per-stage stall, bit0 = PC ... bit5 = WB
//   flush            registered pipeline flush / new_pc load strobe
//   new_pc[31:0]     registered redirect target, valid while flush==1
//   stall_timeout    sticky flag, stall[0] held for STALL_TIMEOUT cycles
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE     = 32'h0000_000e,
  parameter int unsigned FLUSH_GAP     = 2,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
);

  localparam int unsigned GAP_W = (FLUSH_GAP > 1) ? $clog2(FLUSH_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (FLUSH_GAP > 0) ? GAP_W'(FLUSH_GAP - 1) : '0;
  localparam logic [15:0] TIMEOUT_LAST = STALL_TIMEOUT - 16'd1;

  typedef enum logic [1:0] {RUN, FLUSH, GAP} state_t;

  state_t           state_reg, state_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [31:0]      new_pc_reg, new_pc_next;
  logic             flush_reg;
  logic [15:0]      stall_cnt_reg;
  logic             stall_timeout_reg;
  logic             exc_take;     // exception accepted this cycle
  logic             stall_kill;   // redirect in progress: nothing may stall
  logic [2:0]       stall_depth;  // number of low-order stages held

  // Next-state / redirect target
  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    new_pc_next  = new_pc_reg;
    exc_take     = 1'b0;
    case (state_reg)
      RUN: begin
        if (excepttype_i != 32'd0) begin
          exc_take    = 1'b1;
          state_next  = FLUSH;
          new_pc_next = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        end
      end
      FLUSH: begin
        if (FLUSH_GAP > 0) begin
          state_next   = GAP;
          gap_cnt_next = GAP_LOAD;
        end else begin
          state_next = RUN;
        end
      end
      GAP: begin
        // Exceptions arriving here are deliberately dropped.
        if (gap_cnt_reg == '0) state_next = RUN;
        else                   gap_cnt_next = gap_cnt_reg - 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= RUN;
      gap_cnt_reg <= '0;
      new_pc_reg  <= 32'd0;
      flush_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= gap_cnt_next;
      new_pc_reg  <= new_pc_next;
      flush_reg   <= (state_next == FLUSH);
    end
  end

  // Stall encoding: a pending or active redirect overrides every request,
  // EX holds PC..EX (4 stages), ID holds PC..ID (3 stages).
  always_comb begin
    stall_kill  = !rst || exc_take || (state_reg == FLUSH);
    stall_depth = 3'd0;
    if (!stall_kill) begin
      if (stallreq_from_ex)      stall_depth = 3'd4;
      else if (stallreq_from_id) stall_depth = 3'd3;
    end
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_stall
      assign stall[gi] = (3'(gi) < stall_depth);
    end
  endgenerate

  // Stall-length monitor. The flag sets on the edge that ends the
  // STALL_TIMEOUT-th consecutive stalled cycle; the counter saturates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg     <= 16'd0;
      stall_timeout_reg <= 1'b0;
    end else if (stall[0]) begin
      if (stall_cnt_reg != 16'hFFFF) stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (stall_cnt_reg >= TIMEOUT_LAST) stall_timeout_reg <= 1'b1;
    end else begin
      stall_cnt_reg <= 16'd0;
    end
  end

  assign flush         = flush_reg;
  assign new_pc        = new_pc_reg;
  assign stall_timeout = stall_timeout_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl.
// Expected values are queued when stimulus is applied and compared when the
// DUT output they refer to becomes valid.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  localparam int SIG_STALL = 0, SIG_FLUSH = 1, SIG_PC = 2, SIG_TO = 3;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .ERET_CODE    (32'h0000_000e),
    .FLUSH_GAP    (2),
    .STALL_TIMEOUT(16'd8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_from_id(stallreq_from_id),
    .stallreq_from_ex(stallreq_from_ex),
    .excepttype_i    (excepttype_i),
    .cp0_epc_i       (cp0_epc_i),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .stall_timeout   (stall_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] observe(int sig);
    case (sig)
      SIG_STALL: observe = {26'd0, stall};
      SIG_FLUSH: observe = {31'd0, flush};
      SIG_PC:    observe = new_pc;
      default:   observe = {31'd0, stall_timeout};
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      n_assert++;
      assert (obs === e.val) begin
        $display("check %s: observed %h expected %h ok", e.tag, obs, e.val);
      end else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b0;
    stallreq_from_id = 1'b0;
    stallreq_from_ex = 1'b1;
    excepttype_i     = 32'd0;
    cp0_epc_i        = 32'd0;

    // 1: reset held 3 cycles with an EX stall request
    for (int i = 0; i < 3; i++) begin
      tick();
      push("rst_stall", SIG_STALL, 32'h0);
      push("rst_flush", SIG_FLUSH, 32'h0);
      push("rst_new_pc", SIG_PC, 32'h0);
      push("rst_timeout", SIG_TO, 32'h0);
      check();
    end
    rst = 1'b1;
    stallreq_from_ex = 1'b0;
    tick();

    // 2: stall priority
    stallreq_from_id = 1'b1; #1;
    push("stall_id", SIG_STALL, 32'h07); check();
    stallreq_from_ex = 1'b1; #1;
    push("stall_ex_id", SIG_STALL, 32'h0f); check();
    stallreq_from_id = 1'b0; stallreq_from_ex = 1'b0; #1;
    push("stall_none", SIG_STALL, 32'h00); check();
    tick();

    // 3: exception, then a second one inside the guard window
    excepttype_i = 32'h1; #1;
    push("exc_stall", SIG_STALL, 32'h0); check();
    push("exc_flush_n0", SIG_FLUSH, 32'h0); check();
    push("exc_flush_n1", SIG_FLUSH, 32'h1);
    push("exc_new_pc", SIG_PC, 32'h20);
    tick(); check();
    excepttype_i = 32'h0;
    tick();
    push("exc_flush_n2", SIG_FLUSH, 32'h0);
    push("exc_pc_hold", SIG_PC, 32'h20);
    check();
    excepttype_i = 32'h1;          // dropped: GAP
    tick();
    excepttype_i = 32'h0;
    push("gap_drop_n3", SIG_FLUSH, 32'h0); check();
    tick();
    push("gap_drop_n4", SIG_FLUSH, 32'h0); check();

    // 4: ERET redirects to EPC
    cp0_epc_i = 32'h0000_0400;
    excepttype_i = 32'he;
    push("eret_flush", SIG_FLUSH, 32'h1);
    push("eret_new_pc", SIG_PC, 32'h400);
    tick(); check();
    excepttype_i = 32'h0;
    for (int i = 0; i < 3; i++) tick();

    // 5: exception colliding with an EX stall request
    excepttype_i = 32'h1; stallreq_from_ex = 1'b1; #1;
    push("coll_exc_stall", SIG_STALL, 32'h0); check();
    push("coll_flush", SIG_FLUSH, 32'h1);
    push("coll_new_pc", SIG_PC, 32'h20);
    tick();
    excepttype_i = 32'h0; #1;
    push("coll_flush_stall", SIG_STALL, 32'h0); check();
    tick();
    push("coll_gap_stall", SIG_STALL, 32'h0f);
    push("coll_gap_flush", SIG_FLUSH, 32'h0);
    check();
    stallreq_from_ex = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // 6: 7-cycle stall must not trip the monitor, 8-cycle stall must
    push("to_pre", SIG_TO, 32'h0); check();
    stallreq_from_ex = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    stallreq_from_ex = 1'b0;
    push("to_7cyc", SIG_TO, 32'h0); check();
    tick();
    push("to_7cyc_after", SIG_TO, 32'h0); check();
    stallreq_from_ex = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    push("to_8cyc_at7", SIG_TO, 32'h0); check();
    tick();
    push("to_8cyc", SIG_TO, 32'h1); check();
    stallreq_from_ex = 1'b0;
    tick(); tick();
    push("to_sticky", SIG_TO, 32'h1); check();

    // Reset during FLUSH aborts the redirect
    excepttype_i = 32'h1;
    push("mid_flush", SIG_FLUSH, 32'h1);
    tick(); check();
    excepttype_i = 32'h0;
    rst = 1'b0;
    push("abort_flush", SIG_FLUSH, 32'h0);
    push("abort_new_pc", SIG_PC, 32'h0);
    push("abort_timeout", SIG_TO, 32'h0);
    tick(); check();
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
